// File: rtl/drisc_bus_pkg.sv
// Shared drisc data-bus definitions: access-size encodings and CLINT register offsets.
package drisc_bus_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_WORD = 2'b10
  } data_size_e;

  localparam int unsigned OFFSET_W = 16;
  localparam int unsigned WIDX_W   = 14;

  localparam logic [OFFSET_W-1:0] MSIP_OFFSET        = 16'h0000;
  localparam logic [OFFSET_W-1:0] MTIMECMP_LO_OFFSET = 16'h4000;
  localparam logic [OFFSET_W-1:0] MTIMECMP_HI_OFFSET = 16'h4004;
  localparam logic [OFFSET_W-1:0] MTIME_LO_OFFSET    = 16'hBFF8;
  localparam logic [OFFSET_W-1:0] MTIME_HI_OFFSET    = 16'hBFFC;

  // Word indices (offset[15:2]) used by the register decode.
  localparam logic [WIDX_W-1:0] MSIP_WIDX        = MSIP_OFFSET[15:2];
  localparam logic [WIDX_W-1:0] MTIMECMP_LO_WIDX = MTIMECMP_LO_OFFSET[15:2];
  localparam logic [WIDX_W-1:0] MTIMECMP_HI_WIDX = MTIMECMP_HI_OFFSET[15:2];
  localparam logic [WIDX_W-1:0] MTIME_LO_WIDX    = MTIME_LO_OFFSET[15:2];
  localparam logic [WIDX_W-1:0] MTIME_HI_WIDX    = MTIME_HI_OFFSET[15:2];

endpackage

// File: rtl/tick_divider.sv
// Prescaler: counts 0..PRESCALE-1 and raises tick for the cycle in which it wraps.
module tick_divider #(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clock,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(PRESCALE - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             tick_q, tick_d;

  // Next count and a registered flag marking the terminal count.
  always_comb begin
    count_d = (count_q == LAST) ? '0 : count_q + CNT_W'(1);
    tick_d  = (count_d == LAST);
  end

  // Counter state; tick reset value reflects count 0 being terminal when PRESCALE is 1.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
      tick_q  <= (PRESCALE == 1);
    end else begin
      count_q <= count_d;
      tick_q  <= tick_d;
    end
  end

  assign tick = tick_q;

endmodule

// File: rtl/machine_timer.sv
// CLINT-style machine timer: 64-bit mtime/mtimecmp, msip, combinational read port.
module machine_timer
  import drisc_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDRESS = 32'h0200_0000,
  parameter int unsigned PRESCALE     = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] address_bus,
  input  logic [31:0] data_bus_in,
  input  logic [1:0]  data_size,
  input  logic        write,
  input  logic        read,
  output logic [31:0] data_bus_out,
  output logic        selected,
  output logic        timer_interrupt,
  output logic        software_interrupt
);

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] shadow_q, shadow_d;
  logic        msip_q, msip_d;
  logic        timer_irq_q, timer_irq_d;

  logic              tick;
  logic              in_region_c;
  logic [WIDX_W-1:0] word_idx_c;
  logic              rd_en_c;
  logic              wr_en_c;
  logic [31:0]       rdata_c;
  logic              unused_addr_bits;

  tick_divider #(
    .PRESCALE (PRESCALE)
  ) u_tick_divider (
    .clock (clock),
    .reset (reset),
    .tick  (tick)
  );

  // Region decode; byte lanes inside the word are left to the core.
  assign in_region_c      = (address_bus[31:16] == BASE_ADDRESS[31:16]);
  assign word_idx_c       = address_bus[15:2];
  assign unused_addr_bits = ^address_bus[1:0];
  assign rd_en_c          = read && in_region_c;
  assign wr_en_c          = write && in_region_c && (data_size == SIZE_WORD);
  assign selected         = in_region_c && (read || write);

  // Read mux over registered state only, so the value is the pre-write one.
  always_comb begin
    rdata_c = '0;
    case (word_idx_c)
      MSIP_WIDX:        rdata_c = {31'b0, msip_q};
      MTIMECMP_LO_WIDX: rdata_c = mtimecmp_q[31:0];
      MTIMECMP_HI_WIDX: rdata_c = mtimecmp_q[63:32];
      MTIME_LO_WIDX:    rdata_c = mtime_q[31:0];
      MTIME_HI_WIDX:    rdata_c = shadow_q;
      default:          rdata_c = '0;
    endcase
  end

  assign data_bus_out = rd_en_c ? rdata_c : '0;

  // Next state: count on tick, word writes override (losing a coincident increment).
  always_comb begin
    mtime_d     = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d  = mtimecmp_q;
    msip_d      = msip_q;
    shadow_d    = shadow_q;
    timer_irq_d = (mtime_q >= mtimecmp_q);

    if (rd_en_c && (word_idx_c == MTIME_LO_WIDX)) begin
      shadow_d = mtime_q[63:32];
    end

    if (wr_en_c) begin
      case (word_idx_c)
        MSIP_WIDX:        msip_d            = data_bus_in[0];
        MTIMECMP_LO_WIDX: mtimecmp_d[31:0]  = data_bus_in;
        MTIMECMP_HI_WIDX: mtimecmp_d[63:32] = data_bus_in;
        MTIME_LO_WIDX:    mtime_d           = {mtime_q[63:32], data_bus_in};
        MTIME_HI_WIDX:    mtime_d           = {data_bus_in, mtime_q[31:0]};
        default:          ;
      endcase
    end
  end

  // Timer state registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mtime_q     <= '0;
      mtimecmp_q  <= '1;
      msip_q      <= 1'b0;
      shadow_q    <= '0;
      timer_irq_q <= 1'b0;
    end else begin
      mtime_q     <= mtime_d;
      mtimecmp_q  <= mtimecmp_d;
      msip_q      <= msip_d;
      shadow_q    <= shadow_d;
      timer_irq_q <= timer_irq_d;
    end
  end

  assign timer_interrupt    = timer_irq_q;
  assign software_interrupt = msip_q;

endmodule
